and4_tester: RTL and testbench

Self-checking stimulus sequencer for the lab's 4-input gate experiments. It drives the four inputs of a 4-input AND unit under test through all 16 combinations, waits a programmable settle time per vector, samples the gate output and compares it against the expected AND of the applied vector. It reports pass/fail, the mismatch count and the first failing vector. It sits on the driving side of the gate's `in0..in3/out0` interface and is wired to the board's clock, reset, button and LEDs.

---
 rtl/and4_tester_pkg.sv | 21 ++
 rtl/and4_tester_settle_counter.sv | 41 ++++
 rtl/and4_tester.sv | 146 ++++++++++++++
 tb/tb_and4_tester.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/and4_tester_pkg.sv
// Shared definitions for the AND4 gate tester: FSM encoding, widths and the
// reference function used for the per-vector compare.
package and4_tester_pkg;

  localparam int VEC_W = 4;  // number of UUT inputs / vector width
  localparam int CNT_W = 8;  // settle counter width (SETTLE up to 255)
  localparam int ERR_W = 5;  // mismatch count 0..16

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Expected output of a healthy 4-input AND for a given input vector.
  function automatic logic expected_and(input logic [VEC_W-1:0] v);
    return &v;
  endfunction

endpackage

// File: rtl/and4_tester_settle_counter.sv
// Settle-time counter: counts cycles a vector has been held and flags the
// last settle cycle (count == SETTLE-1). Synchronous clear, enable-gated.
module and4_tester_settle_counter
  import and4_tester_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit_o = (count_q == LIMIT);

endmodule

// File: rtl/and4_tester.sv
// Sweeps a 4-input AND UUT through all 16 input vectors, holds each for
// SETTLE cycles, checks the UUT output on one CHECK cycle and reports
// pass/fail, the mismatch count and the first failing vector.
//
// Handshake: start is a one-cycle request with no back-pressure. It is
// accepted on a rising edge only when busy is low (IDLE or DONE); while busy
// it is ignored. Acceptance is visible as busy=1 after that edge.
module and4_tester
  import and4_tester_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_in0,
  output logic             dut_in1,
  output logic             dut_in2,
  output logic             dut_in3,
  input  logic             dut_out0,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] ff_q, ff_d;
  logic             flag_q, flag_d;
  logic [VEC_W-1:0] din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic cnt_clr;
  logic cnt_en;
  logic at_limit;
  logic mismatch;

  and4_tester_settle_counter #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .at_limit_o(at_limit)
  );

  // Next-state, result bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    ff_d     = ff_q;
    flag_d   = flag_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    mismatch = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          flag_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (at_limit) begin
          state_d = ST_CHECK;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_CHECK: begin
        mismatch = (dut_out0 != expected_and(vec_q));
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!flag_q) begin
            ff_d   = vec_q;
            flag_d = 1'b1;
          end
        end
        // Compare uses vec_q before the increment, so 15 never wraps to 0.
        if (vec_q == {VEC_W{1'b1}}) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
    din_d  = busy_d ? vec_d : '0;
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      flag_q  <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      flag_q  <= flag_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in0    = din_q[0];
  assign dut_in1    = din_q[1];
  assign dut_in2    = din_q[2];
  assign dut_in3    = din_q[3];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_and4_tester.sv
// Bench for and4_tester: two testers (SETTLE=1 and SETTLE=3) share clock,
// reset and start and each drives its own behavioural UUT. Expected results
// come from a vector-by-vector reference sweep computed in the bench.
module tb_and4_tester;
  import and4_tester_pkg::*;

  localparam int S_A = 1;
  localparam int S_B = 3;
  localparam int LEN_A = 16 * (S_A + 1);
  localparam int LEN_B = 16 * (S_B + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic a_in0, a_in1, a_in2, a_in3, a_out, a_busy, a_done, a_pass;
  logic b_in0, b_in1, b_in2, b_in3, b_out, b_busy, b_done, b_pass;
  logic [4:0] a_err, b_err;
  logic [3:0] a_ff, b_ff;
  state_e a_state, b_state;
  logic [3:0] a_vec, b_vec;

  int          uut_mode;  // 0 good, 1 stuck0, 2 stuck1, 3 in3 high, 4 random flips
  logic [15:0] uut_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];
  logic [3:0] act_q[$];

  and4_tester #(.SETTLE(S_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_in0(a_in0), .dut_in1(a_in1), .dut_in2(a_in2), .dut_in3(a_in3),
    .dut_out0(a_out), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .first_fail(a_ff), .dbg_state(a_state)
  );

  and4_tester #(.SETTLE(S_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_in0(b_in0), .dut_in1(b_in1), .dut_in2(b_in2), .dut_in3(b_in3),
    .dut_out0(b_out), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .first_fail(b_ff), .dbg_state(b_state)
  );

  // ---------------- behavioural UUTs ----------------
  function automatic logic uut_resp(input int mode, input logic [15:0] mask,
                                    input logic [3:0] v);
    case (mode)
      0:       return (v == 4'hF);
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (v[2:0] == 3'b111);
      default: return (v == 4'hF) ^ mask[v];
    endcase
  endfunction

  assign a_vec = {a_in3, a_in2, a_in1, a_in0};
  assign b_vec = {b_in3, b_in2, b_in1, b_in0};
  assign a_out = uut_resp(uut_mode, uut_mask, a_vec);
  assign b_out = uut_resp(uut_mode, uut_mask, b_vec);

  // ---------------- reference model ----------------
  task automatic ref_sweep(output int errs, output int ffail);
    errs  = 0;
    ffail = 0;
    for (int v = 0; v < 16; v++) begin
      if (uut_resp(uut_mode, uut_mask, 4'(v)) != (v == 15)) begin
        if (errs == 0) ffail = v;
        errs++;
      end
    end
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_a_in"},    32'(a_vec), 0);
    check_eq({tag, "_a_busy"},  32'(a_busy), 0);
    check_eq({tag, "_a_done"},  32'(a_done), 0);
    check_eq({tag, "_a_pass"},  32'(a_pass), 0);
    check_eq({tag, "_a_err"},   32'(a_err), 0);
    check_eq({tag, "_a_ff"},    32'(a_ff), 0);
    check_eq({tag, "_a_state"}, 32'(a_state), 0);
    check_eq({tag, "_b_in"},    32'(b_vec), 0);
    check_eq({tag, "_b_busy"},  32'(b_busy), 0);
    check_eq({tag, "_b_done"},  32'(b_done), 0);
    check_eq({tag, "_b_err"},   32'(b_err), 0);
    check_eq({tag, "_b_ff"},    32'(b_ff), 0);
  endtask

  // ---------------- driver: one full sweep ----------------
  // mid_start >= 0 pulses start again that many cycles into the sweep.
  task automatic run_sweep(input int mid_start);
    int  exp_err, exp_ff;
    int  cnt_a, cnt_b, cyc;
    logic       prev_busy;
    logic [3:0] prev_in;
    ref_sweep(exp_err, exp_ff);
    exp_q.delete();
    act_q.delete();
    for (int v = 0; v < 16; v++) exp_q.push_back(4'(v));

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("accept_a_busy", 32'(a_busy), 1);
    check_eq("accept_a_done", 32'(a_done), 0);
    check_eq("accept_a_err",  32'(a_err), 0);
    check_eq("accept_b_done", 32'(b_done), 0);

    cnt_a = 0; cnt_b = 0; prev_busy = 1'b0; prev_in = '0;
    for (cyc = 0; cyc < 400 && !(a_done && b_done); cyc++) begin
      if (a_busy) begin
        cnt_a++;
        if (!prev_busy || a_vec != prev_in) act_q.push_back(a_vec);
      end
      if (b_busy) cnt_b++;
      prev_busy = a_busy;
      prev_in   = a_vec;
      start = (cyc == mid_start);
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("sweep_finished", 32'(a_done && b_done), 1);
    check_eq("busy_len_a", cnt_a, LEN_A);
    check_eq("busy_len_b", cnt_b, LEN_B);
    check_eq("a_pass",  32'(a_pass), 32'(exp_err == 0));
    check_eq("a_err",   32'(a_err), exp_err);
    check_eq("a_ff",    32'(a_ff), exp_ff);
    check_eq("a_in_idle", 32'(a_vec), 0);
    check_eq("b_pass",  32'(b_pass), 32'(exp_err == 0));
    check_eq("b_err",   32'(b_err), exp_err);
    check_eq("b_ff",    32'(b_ff), exp_ff);
    check_eq("b_busy_low", 32'(b_busy), 0);
    check_eq("vec_seq_len", act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0)
      check_eq("vec_seq", 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int found;
    rst_n = 1'b0;
    start = 1'b0;
    uut_mode = 0;
    uut_mask = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    uut_mode = 0; run_sweep(-1);   // good UUT
    uut_mode = 1; run_sweep(5);    // stuck-at-0, start from DONE, start while busy
    uut_mode = 2; run_sweep(12);   // stuck-at-1
    uut_mode = 3; run_sweep(-1);   // in3 open (reads high)

    // Reset in the middle of a sweep, at vector 5 in SETTLE.
    uut_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (a_vec == 4'd5 && a_state == ST_SETTLE) found = 1;
      else @(negedge clk);
    end
    check_eq("reach_vec5", found, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(-1);

    // Randomised UUT faults.
    for (int k = 0; k < 6; k++) begin
      uut_mode = 4;
      uut_mask = 16'($urandom);
      run_sweep(int'($urandom_range(0, 25)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
